relu_backprop_gate: RTL

- Backward-pass counterpart of the forward thresholded activation used in the neuron datapath.
- Captures one layer's pre-activation values (N_NEURONS words) and stores only the derivative mask bit for each.
- Then streams incoming error/gradient words through, zeroing every gradient whose neuron was clipped in the forward pass.
- Sits between the layer's error-propagation stage and the weight-update stage.

---
 rtl/relu_backprop_gate.sv | 116 +++++++++++
 1 files changed

// File: rtl/relu_backprop_gate.sv
// Backward-pass ReLU gate: loads one layer of pre-activations as a derivative
// mask, then streams gradients through, zeroing those of clipped neurons.
module relu_backprop_gate #(
   parameter int          N_NEURONS = 8,
   parameter int          CNT_W     = 3,
   parameter logic [14:0] THRESH    = 15'h0100
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fwd_valid,
   output logic                 fwd_ready,
   input  logic [15:0]          fwd_data,
   input  logic                 grad_valid,
   output logic                 grad_ready,
   input  logic [15:0]          grad_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [15:0]          out_data,
   output logic                 out_last,
   output logic                 layer_done,
   output logic [N_NEURONS-1:0] mask
);

   typedef enum logic [1:0] {LOAD, GATE, DRAIN} state_t;

   state_t                 r_state;
   logic [CNT_W-1:0]       r_idx;
   logic [N_NEURONS-1:0]   r_mask;
   logic                   r_fwdReady;
   logic                   r_outValid;
   logic [15:0]            r_outData;
   logic                   r_outLast;
   logic                   r_layerDone;

   logic w_fwdHs;
   logic w_gradHs;
   logic w_outHs;
   logic w_idxLast;
   logic w_maskBit;
   logic w_gradReady;

   // Derivative is 1 only where the forward pass let the value through.
   assign w_maskBit   = ~fwd_data[15] & (fwd_data[14:0] > THRESH);
   assign w_idxLast   = (r_idx == CNT_W'(N_NEURONS - 1));
   assign w_gradReady = (r_state == GATE) & (~r_outValid | out_ready);
   assign w_fwdHs     = fwd_valid & r_fwdReady;
   assign w_gradHs    = grad_valid & w_gradReady;
   assign w_outHs     = r_outValid & out_ready;

   assign fwd_ready  = r_fwdReady;
   assign grad_ready = w_gradReady;
   assign out_valid  = r_outValid;
   assign out_data   = r_outData;
   assign out_last   = r_outLast;
   assign layer_done = r_layerDone;
   assign mask       = r_mask;

   // fwd_ready is registered so it stays low until the first edge after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= LOAD;
         r_idx       <= '0;
         r_mask      <= '0;
         r_fwdReady  <= 1'b0;
         r_outValid  <= 1'b0;
         r_outData   <= 16'h0000;
         r_outLast   <= 1'b0;
         r_layerDone <= 1'b0;
      end else begin
         r_layerDone <= 1'b0;
         case (r_state)
            LOAD: begin
               r_fwdReady <= 1'b1;
               if (w_fwdHs) begin
                  r_mask[r_idx] <= w_maskBit;
                  if (w_idxLast) begin
                     r_idx      <= '0;
                     r_state    <= GATE;
                     r_fwdReady <= 1'b0;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            GATE: begin
               if (w_gradHs) begin
                  r_outData  <= r_mask[r_idx] ? grad_data : 16'h0000;
                  r_outValid <= 1'b1;
                  r_outLast  <= w_idxLast;
                  if (w_idxLast) begin
                     r_state <= DRAIN;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end else if (w_outHs) begin
                  r_outValid <= 1'b0;
               end
            end
            DRAIN: begin
               if (w_outHs && r_outLast) begin
                  r_outValid  <= 1'b0;
                  r_layerDone <= 1'b1;
                  r_mask      <= '0;
                  r_idx       <= '0;
                  r_state     <= LOAD;
                  r_fwdReady  <= 1'b1;
               end
            end
            default: begin
               r_state <= LOAD;
            end
         endcase
      end
   end

endmodule
